// File: rtl/fight_pkg.sv
// Shared action codes and button indices for the player encoder and combat FSM.
package fight_pkg;

    typedef logic [2:0] action_t;

    localparam action_t KICK  = 3'b000;
    localparam action_t PUNCH = 3'b001;
    localparam action_t WAIT  = 3'b010;
    localparam action_t JUMP  = 3'b011;
    localparam action_t LEFT  = 3'b100;
    localparam action_t RIGHT = 3'b101;

    localparam int NUM_BTN   = 5;
    localparam int BTN_KICK  = 0;
    localparam int BTN_PUNCH = 1;
    localparam int BTN_JUMP  = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 4;

    function automatic action_t btn_to_action(input logic [2:0] idx);
        case (idx)
            3'd0:    return KICK;
            3'd1:    return PUNCH;
            3'd2:    return JUMP;
            3'd3:    return LEFT;
            3'd4:    return RIGHT;
            default: return WAIT;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, stability counter, registered rising-edge pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic       sync1;
    logic       sync2;
    logic [7:0] cnt;

    // Level flips one cycle after the counter has seen DEB_CYCLES differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 != level) begin
                if (cnt == 8'(DEB_CYCLES)) begin
                    level <= ~level;
                    rise  <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/player_action_encoder.sv
// Buttons -> prioritised, rate-limited, FIFO-buffered action codes.
// Optional auto-repeat of held left/right: define PLAYER_ACTION_REPEAT_EN.
module player_action_encoder
    import fight_pkg::*;
#(
    parameter int DEB_CYCLES    = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int COOLDOWN      = 8,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    btn_raw,
    output action_t       action,
    output logic          action_valid,
    input  logic          action_ready,
    output logic          drop,
    output logic          fifo_full
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic [NUM_BTN-1:0] deb_level;
    logic [NUM_BTN-1:0] deb_rise;
    logic [NUM_BTN-1:0] rise_eff;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] clr;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_deb
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[b]),
            .level (deb_level[b]),
            .rise  (deb_rise[b])
        );
    end

`ifdef PLAYER_ACTION_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [1:0] rep_hit;
    logic       unused_ok;

    for (genvar j = 0; j < 2; j++) begin : g_rep
        localparam int IDX = BTN_LEFT + j;
        logic [RW-1:0] rep_cnt;

        // Restarts on the initial press so repeats land every REPEAT_CYCLES after it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rep_cnt <= '0;
            end else if (!deb_level[IDX] || deb_rise[IDX] || rep_hit[j]) begin
                rep_cnt <= '0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end

        assign rep_hit[j] = deb_level[IDX] && !deb_rise[IDX] &&
                            (rep_cnt == RW'(REPEAT_CYCLES - 1));
    end

    assign rise_eff  = deb_rise | {rep_hit, 3'b000};
    assign unused_ok = ^deb_level[2:0];
`else
    logic unused_ok;
    assign rise_eff  = deb_rise;
    assign unused_ok = ^{deb_level, (REPEAT_CYCLES > 0)};
`endif

    action_t          mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_next, wr_ptr_next;
    logic [CW-1:0]    count, count_next;
    logic [CD_W-1:0]  cooldown;

    logic       full, pop, push, is_atk, cd_drop, merge_drop, sel_vld;
    logic [2:0] sel;
    action_t    push_code;

    assign full = (count == CW'(FIFO_DEPTH));
    assign pop  = action_valid && action_ready;

    // Arbiter: lowest index wins; attacks under cooldown are discarded.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        push    = 1'b0;
        clr     = '0;
        cd_drop = 1'b0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel     = 3'(i);
                sel_vld = 1'b1;
            end
        end
        push_code = btn_to_action(sel);
        is_atk    = (sel == 3'(BTN_KICK)) || (sel == 3'(BTN_PUNCH));
        if (sel_vld) begin
            if (is_atk && cooldown != '0) begin
                clr[sel] = 1'b1;
                cd_drop  = 1'b1;
            end else if (!full || pop) begin
                push     = 1'b1;
                clr[sel] = 1'b1;
            end
        end
    end

    assign merge_drop = |(rise_eff & pending & ~clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            drop     <= 1'b0;
            cooldown <= '0;
        end else begin
            pending <= (pending & ~clr) | rise_eff;
            drop    <= merge_drop | cd_drop;
            if (push && is_atk) begin
                cooldown <= CD_W'(COOLDOWN);
            end else if (cooldown != '0) begin
                cooldown <= cooldown - 1'b1;
            end
        end
    end

    always_comb begin
        rd_ptr_next = pop  ? rd_ptr + 1'b1 : rd_ptr;
        wr_ptr_next = push ? wr_ptr + 1'b1 : wr_ptr;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_code;
        end
    end

    // Head is registered; a push landing at the next read slot bypasses the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            action       <= WAIT;
            action_valid <= 1'b0;
            fifo_full    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            action_valid <= (count_next != '0);
            fifo_full    <= (count_next == CW'(FIFO_DEPTH));
            if (count_next == '0) begin
                action <= WAIT;
            end else if (push && wr_ptr == rd_ptr_next) begin
                action <= push_code;
            end else begin
                action <= mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: tb/tb_player_action_encoder.sv
// Directed bench for player_action_encoder with default parameters.
module tb_player_action_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn_raw;
    logic       action_ready;
    logic [2:0] action;
    logic       action_valid;
    logic       drop;
    logic       fifo_full;

    int n_chk = 0;
    int n_fail = 0;
    int drop_cnt = 0;
    int right_pops = 0;
    int d0;

    typedef struct {
        int         bidx;
        logic [2:0] code;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    player_action_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .action       (action),
        .action_valid (action_valid),
        .action_ready (action_ready),
        .drop         (drop),
        .fifo_full    (fifo_full)
    );

    always @(posedge clk) begin
        if (drop) drop_cnt++;
        if (action_valid && action_ready && action == 3'b101) right_pops++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input int b);
        btn_raw[b] = 1'b1;
        step(10);
        btn_raw[b] = 1'b0;
        step(10);
    endtask

    task automatic pop1;
        action_ready = 1'b1;
        step(1);
        action_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0, 3'b000};
        tbl[1] = '{1, 3'b001};
        tbl[2] = '{2, 3'b011};
        tbl[3] = '{3, 3'b100};
        tbl[4] = '{4, 3'b101};

        // Reset with kick held
        rst_n = 1'b0;
        btn_raw = 5'b00001;
        action_ready = 1'b0;
        step(3);
        chk("rst_action", action, 3'b010);
        chk("rst_valid", action_valid, 0);
        chk("rst_drop", drop, 0);
        chk("rst_full", fifo_full, 0);
        rst_n = 1'b1;
        step(8);
        chk("lat_t8_valid", action_valid, 0);
        step(1);
        chk("lat_t9_valid", action_valid, 1);
        chk("lat_t9_action", action, 3'b000);
        pop1();
        chk("pop_action_wait", action, 3'b010);
        chk("pop_valid", action_valid, 0);
        btn_raw = 5'b0;
        step(20);

        // Single-button table
        for (int k = 0; k < 5; k++) begin
            btn_raw[tbl[k].bidx] = 1'b1;
            step(9);
            chk($sformatf("tbl%0d_valid", k), action_valid, 1);
            chk($sformatf("tbl%0d_code", k), action, tbl[k].code);
            btn_raw = 5'b0;
            pop1();
            chk($sformatf("tbl%0d_empty", k), action_valid, 0);
            step(20);
        end

        // Glitch shorter than debounce window
        d0 = drop_cnt;
        btn_raw = 5'b00100;
        step(3);
        btn_raw = 5'b0;
        step(20);
        chk("glitch_valid", action_valid, 0);
        chk("glitch_drop", drop_cnt - d0, 0);

        // Simultaneous jump/left/right
        btn_raw = 5'b11100;
        action_ready = 1'b1;
        step(9);
        chk("sim_jump", action, 3'b011);
        step(1);
        chk("sim_left", action, 3'b100);
        step(1);
        chk("sim_right", action, 3'b101);
        step(1);
        chk("sim_empty", action_valid, 0);
        action_ready = 1'b0;
        btn_raw = 5'b0;
        step(20);

        // Cooldown drops a punch arriving just after a kick push
        d0 = drop_cnt;
        btn_raw = 5'b00001;
        step(2);
        btn_raw = 5'b00011;
        step(7);
        chk("cd_kick", action, 3'b000);
        chk("cd_drop_t9", drop, 0);
        step(1);
        chk("cd_drop_t10", drop, 0);
        step(1);
        chk("cd_drop_t11", drop, 1);
        step(1);
        chk("cd_drop_t12", drop, 0);
        chk("cd_drop_count", drop_cnt - d0, 1);
        btn_raw = 5'b0;
        pop1();
        chk("cd_empty", action_valid, 0);
        step(20);
        btn_raw = 5'b00010;
        step(9);
        chk("cd_punch_ok", action, 3'b001);
        chk("cd_punch_valid", action_valid, 1);
        btn_raw = 5'b0;
        pop1();
        step(20);

        // Overflow: four fill the FIFO, fifth waits, sixth merges into a drop
        d0 = drop_cnt;
        press(0);
        press(1);
        press(2);
        chk("ovf_not_full3", fifo_full, 0);
        press(3);
        chk("ovf_full4", fifo_full, 1);
        press(4);
        chk("ovf_full5", fifo_full, 1);
        chk("ovf_no_drop5", drop_cnt - d0, 0);
        chk("ovf_head", action, 3'b000);
        press(4);
        chk("ovf_drop6", drop_cnt - d0, 1);
        pop1();
        chk("ovf_pop_full", fifo_full, 1);
        chk("ovf_pop_head", action, 3'b001);
        pop1();
        chk("ovf_d1", action, 3'b011);
        pop1();
        chk("ovf_d2", action, 3'b100);
        pop1();
        chk("ovf_d3", action, 3'b101);
        chk("ovf_d3_notfull", fifo_full, 0);
        pop1();
        chk("ovf_empty", action_valid, 0);
        chk("ovf_drop_total", drop_cnt - d0, 1);
        step(10);

        // Held right: one action, or repeats when auto-repeat is built
        right_pops = 0;
        action_ready = 1'b1;
        btn_raw = 5'b10000;
        step(60);
        btn_raw = 5'b0;
        step(30);
        action_ready = 1'b0;
`ifdef PLAYER_ACTION_REPEAT_EN
        chk("hold_right_pops", right_pops, 4);
`else
        chk("hold_right_pops", right_pops, 1);
`endif
        step(5);

        // Reset mid-operation discards the queue silently
        btn_raw = 5'b00100;
        step(12);
        chk("mid_valid_before", action_valid, 1);
        d0 = drop_cnt;
        rst_n = 1'b0;
        btn_raw = 5'b0;
        #1;
        chk("mid_rst_valid", action_valid, 0);
        chk("mid_rst_action", action, 3'b010);
        step(3);
        rst_n = 1'b1;
        step(15);
        chk("mid_after_valid", action_valid, 0);
        chk("mid_after_drop", drop_cnt - d0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
